// File: rtl/userio_pkg.sv
// userio_pkg: SPI mode encodings and FSM state type shared by the userio SPI slave.
package userio_pkg;

    // {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/userio_sync.sv
// userio_sync: N-stage flop synchroniser with a configurable reset level.
import userio_pkg::*;

module userio_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // shift the asynchronous input through the chain; the last stage is the synchronised copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/userio_spi_slave.sv
// userio_spi_slave: SPI slave for the OSD/userio command path, fully oversampled in clk.
// sck, _scs and sdi are synchronised and edge-detected; nothing is clocked by sck.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | deselected; waits for _scs low, CPHA=0 preloads first TX word
//  ST_SHIFT | selected; samples sdi / shifts sdo on detected sck edges
import userio_pkg::*;

module userio_spi_slave #(
    parameter int   WIDTH       = 8,
    parameter logic CPOL        = 1'b0,
    parameter logic CPHA        = 1'b0,
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_W       = 8,
    parameter logic TX_FILL     = 1'b0
) (
    input  logic             clk,
    input  logic             _reset,
    input  logic             _scs,
    input  logic             sck,
    input  logic             sdi,
    output logic             sdo,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_load,
    output logic             tx_underrun,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_first,
    output logic [CNT_W-1:0] rx_count,
    output logic             rx_abort,
    output logic             active
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state;
    logic             sck_s;
    logic             scs_s;
    logic             sdi_s;
    logic             sck_d;
    logic             lead_edge;
    logic             trail_edge;
    logic             sample_edge;
    logic             shift_edge;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-2:0] rx_sh;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] load_word;

    userio_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sck (
        .clk   (clk),
        .rst_n (_reset),
        .d     (sck),
        .q     (sck_s)
    );

    userio_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_scs (
        .clk   (clk),
        .rst_n (_reset),
        .d     (_scs),
        .q     (scs_s)
    );

    userio_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk   (clk),
        .rst_n (_reset),
        .d     (sdi),
        .q     (sdi_s)
    );

    // delayed copy of the synchronised clock for edge detection
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            sck_d <= CPOL;
        end else begin
            sck_d <= sck_s;
        end
    end

    assign lead_edge   = (sck_d == CPOL) && (sck_s != CPOL);
    assign trail_edge  = (sck_d != CPOL) && (sck_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    // an empty transmit handshake sends a word made of the fill bit
    assign load_word = tx_valid ? tx_data : {WIDTH{TX_FILL}};

    // gated by the raw select so sdo drops the moment the host deselects
    assign sdo = ~_scs & tx_sh[WIDTH-1];

    // transfer FSM: word assembly, TX handshake, counters and single-cycle status pulses
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_first    <= 1'b0;
            rx_count    <= '0;
            rx_abort    <= 1'b0;
            tx_load     <= 1'b0;
            tx_underrun <= 1'b0;
            active      <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            rx_abort    <= 1'b0;
            tx_load     <= 1'b0;
            tx_underrun <= 1'b0;
            case (state)
                ST_IDLE: begin
                    active <= 1'b0;
                    if (!scs_s) begin
                        state    <= ST_SHIFT;
                        active   <= 1'b1;
                        bit_cnt  <= '0;
                        rx_count <= '0;
                        // CPHA=0 hosts sample on the first edge, so the MSB must already be out
                        if (!CPHA) begin
                            tx_sh       <= load_word;
                            tx_load     <= 1'b1;
                            tx_underrun <= ~tx_valid;
                        end
                    end
                end
                ST_SHIFT: begin
                    active <= 1'b1;
                    if (scs_s) begin
                        // deselect has priority over any sck edge seen in the same cycle
                        state    <= ST_IDLE;
                        active   <= 1'b0;
                        rx_abort <= (bit_cnt != '0);
                        bit_cnt  <= '0;
                    end else begin
                        if (sample_edge) begin
                            rx_sh <= {rx_sh[WIDTH-3:0], sdi_s};
                            if (bit_cnt == LAST_BIT) begin
                                rx_data  <= {rx_sh, sdi_s};
                                rx_valid <= 1'b1;
                                rx_first <= (rx_count == '0);
                                if (rx_count != '1) begin
                                    rx_count <= rx_count + 1'b1;
                                end
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        if (shift_edge) begin
                            if (bit_cnt == '0) begin
                                tx_sh       <= load_word;
                                tx_load     <= 1'b1;
                                tx_underrun <= ~tx_valid;
                            end else begin
                                tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_userio_spi_slave.sv
// tb_userio_spi_slave: two slaves (8-bit mode 0 with CNT_W=2/TX_FILL=1, 16-bit mode 3)
// driven by a behavioural SPI host; expected words come from what the host sent and
// what the bench offered on the TX handshake.
module tb_userio_spi_slave;

    localparam int H = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    // free-running cycle counter for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: WIDTH=8, mode 0
    logic       scs_a, sck_a, sdi_a, sdo_a;
    logic [7:0] tx_data_a, rx_data_a;
    logic       txv_a, tx_load_a, tx_und_a, rx_valid_a, rx_first_a, rx_abort_a, active_a;
    logic [1:0] rx_count_a;
    logic [7:0] txw_a [8];
    int         txi_a = 0;

    // instance B: WIDTH=16, mode 3
    logic        scs_b, sck_b, sdi_b, sdo_b;
    logic [15:0] tx_data_b, rx_data_b;
    logic        txv_b, tx_load_b, tx_und_b, rx_valid_b, rx_first_b, rx_abort_b, active_b;
    logic [7:0]  rx_count_b;
    logic [15:0] txw_b [8];
    int          txi_b = 0;

    assign tx_data_a = txw_a[txi_a[2:0]];
    assign tx_data_b = txw_b[txi_b[2:0]];

    userio_spi_slave #(
        .WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2), .CNT_W(2), .TX_FILL(1'b1)
    ) dut_a (
        .clk(clk), ._reset(rst_n), ._scs(scs_a), .sck(sck_a), .sdi(sdi_a), .sdo(sdo_a),
        .tx_data(tx_data_a), .tx_valid(txv_a), .tx_load(tx_load_a), .tx_underrun(tx_und_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_first(rx_first_a),
        .rx_count(rx_count_a), .rx_abort(rx_abort_a), .active(active_a)
    );

    userio_spi_slave #(
        .WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2), .CNT_W(8), .TX_FILL(1'b0)
    ) dut_b (
        .clk(clk), ._reset(rst_n), ._scs(scs_b), .sck(sck_b), .sdi(sdi_b), .sdo(sdo_b),
        .tx_data(tx_data_b), .tx_valid(txv_b), .tx_load(tx_load_b), .tx_underrun(tx_und_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_first(rx_first_b),
        .rx_count(rx_count_b), .rx_abort(rx_abort_b), .active(active_b)
    );

    // monitor records
    logic [7:0]  rxd_a [256];
    logic        rxf_a [256];
    int          rxc_a [256];
    int          nrx_a = 0, nload_a = 0, nund_a = 0, nabort_a = 0;
    logic [15:0] rxd_b [64];
    logic        rxf_b [64];
    int          nrx_b = 0, nload_b = 0, nund_b = 0, nabort_b = 0;
    int          rxv_cyc_b = 0;

    // capture every pulse away from the active edge; advance the TX queue on each load
    always @(negedge clk) begin
        if (rx_valid_a && nrx_a < 256) begin
            rxd_a[nrx_a] <= rx_data_a;
            rxf_a[nrx_a] <= rx_first_a;
            rxc_a[nrx_a] <= int'(rx_count_a);
            nrx_a        <= nrx_a + 1;
        end
        if (tx_load_a)  begin nload_a <= nload_a + 1; txi_a <= txi_a + 1; end
        if (tx_und_a)   nund_a   <= nund_a + 1;
        if (rx_abort_a) nabort_a <= nabort_a + 1;
        if (rx_valid_b && nrx_b < 64) begin
            rxd_b[nrx_b] <= rx_data_b;
            rxf_b[nrx_b] <= rx_first_b;
            nrx_b        <= nrx_b + 1;
            rxv_cyc_b    <= cyc;
        end
        if (tx_load_b)  begin nload_b <= nload_b + 1; txi_b <= txi_b + 1; end
        if (tx_und_b)   nund_b   <= nund_b + 1;
        if (rx_abort_b) nabort_b <= nabort_b + 1;
    end

    // host-side buffers
    logic [15:0] mosi [8];
    logic [15:0] miso [8];
    int          last_edge_cyc = 0;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_scs(input int inst, input logic v);
        if (inst == 0) scs_a = v; else scs_b = v;
    endtask

    task automatic set_sck(input int inst, input logic v);
        if (inst == 0) sck_a = v; else sck_b = v;
    endtask

    task automatic set_sdi(input int inst, input logic v);
        if (inst == 0) sdi_a = v; else sdi_b = v;
    endtask

    function automatic logic get_sdo(input int inst);
        return (inst == 0) ? sdo_a : sdo_b;
    endfunction

    // behavioural SPI master; abort_bits>0 deselects after that many bits
    task automatic spi_xfer(input int inst, input int nbits, input int nwords, input int abort_bits);
        logic cpol, cpha;
        int   total, w, b;
        cpol  = (inst == 1);
        cpha  = (inst == 1);
        total = (abort_bits > 0) ? abort_bits : nbits * nwords;
        for (int k = 0; k < 8; k++) miso[k] = '0;
        set_scs(inst, 1'b0);
        wait_clk(H);
        for (int i = 0; i < total; i++) begin
            w = i / nbits;
            b = nbits - 1 - (i % nbits);
            if (!cpha) begin
                set_sdi(inst, mosi[w][b]);
                wait_clk(H);
                miso[w][b] = get_sdo(inst);
                set_sck(inst, ~cpol);
                last_edge_cyc = cyc;
                wait_clk(H);
                if (i != total - 1) set_sck(inst, cpol);
            end else begin
                set_sck(inst, ~cpol);
                set_sdi(inst, mosi[w][b]);
                wait_clk(H);
                miso[w][b] = get_sdo(inst);
                set_sck(inst, cpol);
                last_edge_cyc = cyc;
                wait_clk(H);
            end
        end
        set_scs(inst, 1'b1);
        #1;
        nvec++;
        if (get_sdo(inst) !== 1'b0) begin
            nerr++;
            $display("FAIL sdo_deselected inst%0d: got %b want 0", inst, get_sdo(inst));
        end
        wait_clk(H);
        set_sck(inst, cpol);
        wait_clk(H);
    endtask

    task automatic test_reset();
        nvec++;
        if ({rx_valid_a, rx_first_a, rx_abort_a, tx_load_a, tx_und_a, active_a, sdo_a} !== 7'b0) begin
            nerr++;
            $display("FAIL reset_flags_a: got %b want 0000000",
                     {rx_valid_a, rx_first_a, rx_abort_a, tx_load_a, tx_und_a, active_a, sdo_a});
        end
        nvec++;
        if (rx_data_a !== 8'h00 || rx_count_a !== 2'd0) begin
            nerr++;
            $display("FAIL reset_data_a: got data %h count %0d want 00 0", rx_data_a, rx_count_a);
        end
        nvec++;
        if ({rx_valid_b, rx_first_b, rx_abort_b, tx_load_b, tx_und_b, active_b, sdo_b} !== 7'b0) begin
            nerr++;
            $display("FAIL reset_flags_b: got %b want 0000000",
                     {rx_valid_b, rx_first_b, rx_abort_b, tx_load_b, tx_und_b, active_b, sdo_b});
        end
        nvec++;
        if (rx_data_b !== 16'h0000 || rx_count_b !== 8'd0) begin
            nerr++;
            $display("FAIL reset_data_b: got data %h count %0d want 0000 0", rx_data_b, rx_count_b);
        end
    endtask

    task automatic test_mode0_basic();
        int br, bl, bu;
        br = nrx_a; bl = nload_a; bu = nund_a;
        mosi[0] = 16'h00A5; mosi[1] = 16'h003C;
        txw_a[3'(txi_a)] = 8'h5A; txw_a[3'(txi_a + 1)] = 8'hC3;
        txv_a = 1'b1;
        spi_xfer(0, 8, 2, 0);
        nvec++;
        if (nrx_a - br != 2) begin nerr++; $display("FAIL m0_rx_pulses: got %0d want 2", nrx_a - br); end
        nvec++;
        if (rxd_a[br] !== 8'hA5 || rxf_a[br] !== 1'b1) begin
            nerr++; $display("FAIL m0_word0: got %h first %b want a5 first 1", rxd_a[br], rxf_a[br]);
        end
        nvec++;
        if (rxd_a[br+1] !== 8'h3C || rxf_a[br+1] !== 1'b0) begin
            nerr++; $display("FAIL m0_word1: got %h first %b want 3c first 0", rxd_a[br+1], rxf_a[br+1]);
        end
        nvec++;
        if (rx_count_a !== 2'd2) begin nerr++; $display("FAIL m0_count: got %0d want 2", rx_count_a); end
        nvec++;
        if (miso[0][7:0] !== 8'h5A || miso[1][7:0] !== 8'hC3) begin
            nerr++; $display("FAIL m0_host_rx: got %h %h want 5a c3", miso[0][7:0], miso[1][7:0]);
        end
        nvec++;
        if (nload_a - bl != 2 || nund_a - bu != 0) begin
            nerr++; $display("FAIL m0_loads: got %0d/%0d want 2/0", nload_a - bl, nund_a - bu);
        end
    endtask

    task automatic test_mode0_random();
        int         br, bl, bu, nw, ex_cnt;
        logic       v;
        logic [7:0] exp_tx [8];
        for (int t = 0; t < 6; t++) begin
            nw = $urandom_range(1, 4);
            v  = 1'($urandom_range(0, 1));
            for (int k = 0; k < nw; k++) begin
                mosi[k] = 16'($urandom_range(0, 255));
                txw_a[3'(txi_a + k)] = 8'($urandom_range(0, 255));
                exp_tx[k] = v ? txw_a[3'(txi_a + k)] : 8'hFF;
            end
            txv_a = v;
            br = nrx_a; bl = nload_a; bu = nund_a;
            spi_xfer(0, 8, nw, 0);
            nvec++;
            if (nrx_a - br != nw) begin
                nerr++; $display("FAIL rnd%0d_rx_pulses: got %0d want %0d", t, nrx_a - br, nw);
            end
            for (int k = 0; k < nw; k++) begin
                ex_cnt = (k + 1 > 3) ? 3 : k + 1;
                nvec++;
                if (rxd_a[br+k] !== mosi[k][7:0] || rxf_a[br+k] !== (k == 0) || rxc_a[br+k] != ex_cnt) begin
                    nerr++;
                    $display("FAIL rnd%0d_rx%0d: got %h/%b/%0d want %h/%b/%0d", t, k,
                             rxd_a[br+k], rxf_a[br+k], rxc_a[br+k], mosi[k][7:0], (k == 0), ex_cnt);
                end
                nvec++;
                if (miso[k][7:0] !== exp_tx[k]) begin
                    nerr++; $display("FAIL rnd%0d_tx%0d: got %h want %h", t, k, miso[k][7:0], exp_tx[k]);
                end
            end
            nvec++;
            if (nload_a - bl != nw || nund_a - bu != (v ? 0 : nw)) begin
                nerr++;
                $display("FAIL rnd%0d_loads: got %0d/%0d want %0d/%0d", t, nload_a - bl, nund_a - bu,
                         nw, (v ? 0 : nw));
            end
        end
    endtask

    task automatic test_underrun();
        int bu, bl;
        bu = nund_a; bl = nload_a;
        txv_a = 1'b0;
        txw_a[3'(txi_a)] = 8'h12;
        mosi[0] = 16'($urandom_range(0, 255));
        spi_xfer(0, 8, 1, 0);
        nvec++;
        if (miso[0][7:0] !== 8'hFF) begin nerr++; $display("FAIL underrun_data: got %h want ff", miso[0][7:0]); end
        nvec++;
        if (nund_a - bu != 1 || nload_a - bl != 1) begin
            nerr++; $display("FAIL underrun_pulses: got und %0d load %0d want 1 1", nund_a - bu, nload_a - bl);
        end
        txv_a = 1'b1;
    endtask

    task automatic test_abort();
        int         br, ba;
        logic [7:0] prev;
        mosi[0] = 16'($urandom_range(0, 255));
        spi_xfer(0, 8, 1, 0);
        prev = mosi[0][7:0];
        br = nrx_a; ba = nabort_a;
        mosi[0] = 16'(~prev);
        spi_xfer(0, 8, 1, 5);
        nvec++;
        if (nabort_a - ba != 1) begin nerr++; $display("FAIL abort_pulse: got %0d want 1", nabort_a - ba); end
        nvec++;
        if (nrx_a - br != 0) begin nerr++; $display("FAIL abort_no_rx: got %0d want 0", nrx_a - br); end
        nvec++;
        if (rx_data_a !== prev) begin nerr++; $display("FAIL abort_keep: got %h want %h", rx_data_a, prev); end
        br = nrx_a;
        mosi[0] = 16'($urandom_range(0, 255));
        spi_xfer(0, 8, 1, 0);
        nvec++;
        if (nrx_a - br != 1 || rxd_a[br] !== mosi[0][7:0] || rxf_a[br] !== 1'b1) begin
            nerr++;
            $display("FAIL abort_next: got n %0d data %h first %b want 1 %h 1", nrx_a - br, rxd_a[br],
                     rxf_a[br], mosi[0][7:0]);
        end
    endtask

    task automatic test_saturation();
        int br;
        int exp_c [5] = '{1, 2, 3, 3, 3};
        for (int k = 0; k < 5; k++) begin
            mosi[k] = 16'($urandom_range(0, 255));
            txw_a[3'(txi_a + k)] = 8'($urandom_range(0, 255));
        end
        // odd last word leaves a 1 in the shifter MSB after the transfer
        txw_a[3'(txi_a + 4)] = txw_a[3'(txi_a + 4)] | 8'h01;
        txv_a = 1'b1;
        br = nrx_a;
        spi_xfer(0, 8, 5, 0);
        for (int k = 0; k < 5; k++) begin
            nvec++;
            if (rxc_a[br+k] != exp_c[k] || rxd_a[br+k] !== mosi[k][7:0]) begin
                nerr++;
                $display("FAIL sat_word%0d: got count %0d data %h want %0d %h", k, rxc_a[br+k],
                         rxd_a[br+k], exp_c[k], mosi[k][7:0]);
            end
        end
    endtask

    task automatic test_mode3();
        int          br, bl, lat;
        logic [15:0] exp_tx [2];
        br = nrx_b; bl = nload_b;
        mosi[0] = 16'h1234;
        txw_b[3'(txi_b)] = 16'hBEEF;
        txv_b = 1'b1;
        spi_xfer(1, 16, 1, 0);
        lat = rxv_cyc_b - last_edge_cyc;
        nvec++;
        if (nrx_b - br != 1 || rxd_b[br] !== 16'h1234 || rxf_b[br] !== 1'b1) begin
            nerr++;
            $display("FAIL m3_rx: got n %0d data %h first %b want 1 1234 1", nrx_b - br, rxd_b[br], rxf_b[br]);
        end
        nvec++;
        if (miso[0] !== 16'hBEEF) begin nerr++; $display("FAIL m3_host_rx: got %h want beef", miso[0]); end
        nvec++;
        if (lat != 3) begin nerr++; $display("FAIL m3_latency: got %0d want 3", lat); end
        nvec++;
        if (nload_b - bl != 1) begin nerr++; $display("FAIL m3_loads: got %0d want 1", nload_b - bl); end
        for (int t = 0; t < 2; t++) begin
            br = nrx_b;
            for (int k = 0; k < 2; k++) begin
                mosi[k] = 16'($urandom_range(0, 65535));
                txw_b[3'(txi_b + k)] = 16'($urandom_range(0, 65535));
                exp_tx[k] = txw_b[3'(txi_b + k)];
            end
            spi_xfer(1, 16, 2, 0);
            for (int k = 0; k < 2; k++) begin
                nvec++;
                if (rxd_b[br+k] !== mosi[k] || miso[k] !== exp_tx[k] || rxf_b[br+k] !== (k == 0)) begin
                    nerr++;
                    $display("FAIL m3_rnd%0d_w%0d: got rx %h tx %h first %b want %h %h %b", t, k,
                             rxd_b[br+k], miso[k], rxf_b[br+k], mosi[k], exp_tx[k], (k == 0));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int br, ba;
        txw_a[3'(txi_a)] = 8'hFF;
        txv_a = 1'b1;
        set_scs(0, 1'b0);
        wait_clk(H);
        for (int i = 0; i < 3; i++) begin
            sdi_a = 1'b1;
            wait_clk(H);
            sck_a = 1'b1;
            wait_clk(H);
            sck_a = 1'b0;
        end
        wait_clk(H);
        br = nrx_a; ba = nabort_a;
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({rx_valid_a, rx_first_a, rx_abort_a, tx_load_a, tx_und_a, active_a, sdo_a} !== 7'b0 ||
            rx_data_a !== 8'h00 || rx_count_a !== 2'd0) begin
            nerr++;
            $display("FAIL midreset_outputs: got flags %b data %h count %0d want 0000000 00 0",
                     {rx_valid_a, rx_first_a, rx_abort_a, tx_load_a, tx_und_a, active_a, sdo_a},
                     rx_data_a, rx_count_a);
        end
        wait_clk(2);
        scs_a = 1'b1; sck_a = 1'b0; sdi_a = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(H);
        nvec++;
        if (nrx_a != br || nabort_a != ba) begin
            nerr++; $display("FAIL midreset_pulses: got rx %0d abort %0d want 0 0", nrx_a - br, nabort_a - ba);
        end
        mosi[0] = 16'h0081;
        spi_xfer(0, 8, 1, 0);
        nvec++;
        if (nrx_a - br != 1 || rxd_a[br] !== 8'h81 || rxf_a[br] !== 1'b1 || rxc_a[br] != 1) begin
            nerr++;
            $display("FAIL midreset_fresh: got n %0d data %h first %b count %0d want 1 81 1 1", nrx_a - br,
                     rxd_a[br], rxf_a[br], rxc_a[br]);
        end
    endtask

    // overall time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        scs_a = 1'b1; sck_a = 1'b0; sdi_a = 1'b0; txv_a = 1'b1;
        scs_b = 1'b1; sck_b = 1'b1; sdi_b = 1'b0; txv_b = 1'b1;
        for (int k = 0; k < 8; k++) begin
            txw_a[k] = '0;
            txw_b[k] = '0;
            mosi[k]  = '0;
            miso[k]  = '0;
        end
        wait_clk(3);
        test_reset();
        rst_n = 1'b1;
        wait_clk(H);
        test_mode0_basic();
        test_mode0_random();
        test_underrun();
        test_abort();
        test_saturation();
        test_mode3();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
